// File: rtl/adc_trigger_capture.sv
// ---------------------------------------------------------------------------
// adc_trigger_capture
//
// Threshold-triggered capture controller for the ADC sample stream. Once
// armed it records samples into a circular buffer. On a rising crossing of
// the threshold it freezes PRE_SAMPLES pre-trigger samples plus POST_SAMPLES
// samples from the trigger onward. The frozen window is then streamed out
// over a valid/ready handshake, oldest sample first.
//
// Optional build macro: AUTO_REARM_EN
//   defined   : after the final word is accepted, go straight back to FILL
//   undefined : return to IDLE and wait for the next arm pulse
//
// Ports:
//   clk         sample clock
//   reset_n     asynchronous active-low reset
//   ADC_IN      raw ADC sample, one per clock
//   threshold   unsigned trigger level
//   arm         single-cycle arm request (IDLE only)
//   abort       return to IDLE on the next edge, discarding any window
//   out_data    captured sample
//   out_valid   out_data valid
//   out_last    final sample of the window
//   out_ready   downstream accept
//   state       IDLE=0, FILL=1, ARMED=2, POST=3, READOUT=4
//   trig_count  completed-capture counter (wraps)
// ---------------------------------------------------------------------------
module adc_trigger_capture #(
  parameter int DATA_W       = 14,
  parameter int PRE_SAMPLES  = 16,
  parameter int POST_SAMPLES = 48
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ADC_IN,
  input  logic [DATA_W-1:0] threshold,
  input  logic              arm,
  input  logic              abort,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [2:0]        state,
  output logic [15:0]       trig_count
);

  localparam int DEPTH  = PRE_SAMPLES + POST_SAMPLES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(PRE_SAMPLES + 1);
  localparam int POST_W = $clog2(POST_SAMPLES + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PRE_SAMPLES - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  RD_DONE   = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    READOUT = 3'd4
  } state_t;

`ifdef AUTO_REARM_EN
  localparam state_t DONE_STATE = FILL;
`else
  localparam state_t DONE_STATE = IDLE;
`endif

  state_t cur_state, next_state;

  logic [DATA_W-1:0] s1, s2;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill_cnt;
  logic [POST_W-1:0] post_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_go;

  logic trig, wr_en, enter_readout, last_xfer, can_issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign state         = cur_state;
  assign trig          = (s1 > threshold) && (s2 <= threshold);
  assign wr_en         = (cur_state == FILL) || (cur_state == ARMED) || (cur_state == POST);
  assign enter_readout = (next_state == READOUT) && (cur_state != READOUT);
  assign last_xfer     = out_valid && out_ready && out_last;
  // The output register may take a new word when empty or being drained.
  assign can_issue     = rd_go && (!out_valid || out_ready);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:    if (arm) next_state = FILL;
      FILL:    if (fill_cnt == FILL_LAST) next_state = ARMED;
      ARMED:   if (trig) next_state = (POST_SAMPLES == 1) ? READOUT : POST;
      POST:    if (post_cnt == POST_LAST) next_state = READOUT;
      READOUT: if (last_xfer) next_state = DONE_STATE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Sample buffer; contents need no reset since they are always overwritten
  // by a full window before being read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s1;
  end

  // Input pipeline, capture counters, readout pointer and output register.
  // The first READOUT cycle only sets rd_go, so the first word appears two
  // edges after entering READOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1         <= '0;
      s2         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      rd_go      <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      trig_count <= '0;
    end else begin
      s1 <= ADC_IN;
      s2 <= s1;
      if (abort) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        fill_cnt  <= '0;
        post_cnt  <= '0;
        rd_cnt    <= '0;
        rd_go     <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        case (cur_state)
          FILL: begin
            wr_ptr   <= ptr_inc(wr_ptr);
            fill_cnt <= fill_cnt + 1'b1;
          end
          ARMED: begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (trig) post_cnt <= POST_W'(1);
          end
          POST: begin
            wr_ptr   <= ptr_inc(wr_ptr);
            post_cnt <= post_cnt + 1'b1;
          end
          READOUT: begin
            rd_go <= 1'b1;
            if (can_issue) begin
              if (rd_cnt != RD_DONE) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
                out_last  <= (rd_cnt == RD_LAST);
                rd_ptr    <= ptr_inc(rd_ptr);
                rd_cnt    <= rd_cnt + 1'b1;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
        if (cur_state != FILL) fill_cnt <= '0;
        // The slot after the final write holds the oldest sample of the window.
        if (enter_readout) begin
          rd_ptr     <= ptr_inc(wr_ptr);
          rd_cnt     <= '0;
          rd_go      <= 1'b0;
          trig_count <= trig_count + 1'b1;
        end
      end
    end
  end

endmodule
